// File: rtl/orb_fast_conv_core.sv
// ORB front-end: 3x3 Gaussian smoothing into the conv SRAM, FAST-9 corner map, then a
// 16-pixel ring overlay per corner. All memories are external synchronous SRAMs.
module orb_fast_conv_core #(
  parameter int NUM_PARAMS  = 8,
  parameter int PARAM_DEPTH = 8,
  parameter int MAX_KERNEL  = 31,
  parameter int X_MAX       = 400,
  parameter int Y_MAX       = 400,
  parameter int PIXEL_DEPTH = 8,
  parameter int START_DELAY = 32
) (
  input  logic                          clk,
  input  logic                          n_rst,
  output logic                          new_trans,
  output logic                          img_done,
  output logic [$clog2(X_MAX):0]        x_addr_img,
  output logic [$clog2(Y_MAX):0]        y_addr_img,
  output logic                          ren_img,
  input  logic [PIXEL_DEPTH-1:0]        rdat_img,
  output logic [$clog2(NUM_PARAMS)-1:0] addr_params,
  output logic                          ren_params,
  input  logic [PARAM_DEPTH-1:0]        rdat_params,
  output logic [$clog2(NUM_PARAMS)-1:0] addr_write_params,
  output logic                          wen_params,
  output logic [PARAM_DEPTH-1:0]        wdat_params,
  output logic [$clog2(X_MAX):0]        x_addr_conv,
  output logic [$clog2(Y_MAX):0]        y_addr_conv,
  output logic                          wen_conv,
  output logic [PIXEL_DEPTH-1:0]        wdat_conv,
  output logic [$clog2(X_MAX):0]        x_addr_conv_fast,
  output logic [$clog2(Y_MAX):0]        y_addr_conv_fast,
  output logic                          ren_conv_fast,
  input  logic [PIXEL_DEPTH-1:0]        rdat_conv_fast,
  output logic [$clog2(X_MAX):0]        x_addr_fast,
  output logic [$clog2(Y_MAX):0]        y_addr_fast,
  output logic                          wen_fast,
  output logic                          wdat_fast,
  output logic                          ren_fast,
  input  logic                          rdat_fast,
  output logic [$clog2(X_MAX):0]        x_addr_circle,
  output logic [$clog2(Y_MAX):0]        y_addr_circle,
  output logic                          wen_circle,
  output logic [PIXEL_DEPTH-1:0]        wdat_circle
);

  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;
  localparam int PW = $clog2(NUM_PARAMS);
  localparam int CW = PIXEL_DEPTH + 1;
  localparam int AW = PIXEL_DEPTH + 4;
  localparam int DW = $clog2(START_DELAY + 1);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_PARAMS = 3'd1;
  localparam logic [2:0] S_CONV   = 3'd2;
  localparam logic [2:0] S_FAST   = 3'd3;
  localparam logic [2:0] S_CIRCLE = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int RING_DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int RING_DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [3:0] tap_weight(input logic [3:0] j);
    case (j)
      4'd4:                     return 4'd4;
      4'd1, 4'd3, 4'd5, 4'd7:   return 4'd2;
      default:                  return 4'd1;
    endcase
  endfunction

  // True when some run of 9 consecutive bits (circular) is all set.
  function automatic logic has_run9(input logic [15:0] v);
    logic [15:0] m;
    m = v;
    for (int s = 1; s < 9; s++) m = m & ((v >> s) | (v << (16 - s)));
    return |m;
  endfunction

  logic [2:0]             r_state;
  logic [DW-1:0]          r_cnt;
  logic [4:0]             r_ph;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic [PARAM_DEPTH-1:0] r_t, r_k, r_fc;
  logic [AW-1:0]          r_acc;
  logic [PIXEL_DEPTH-1:0] r_p;
  logic [14:0]            r_bright, r_dark;

  int             w_xi, w_yi, w_tdx, w_tdy;
  logic           w_bypass, w_border, w_x_last, w_y_last, w_pix_done;
  logic           w_b, w_d, w_corner;
  logic [4:0]     w_ntaps;
  logic [3:0]     w_ring_idx, w_cap_idx;
  logic [AW-1:0]  w_sum;
  logic [CW-1:0]  w_c9, w_p9, w_t9;

  assign w_xi     = int'(r_x);
  assign w_yi     = int'(r_y);
  assign w_bypass = (r_k == PARAM_DEPTH'(1)) || (MAX_KERNEL < 3);
  assign w_ntaps  = w_bypass ? 5'd1 : 5'd9;
  assign w_tdx    = w_bypass ? 0 : (int'(r_ph) % 3) - 1;
  assign w_tdy    = w_bypass ? 0 : (int'(r_ph) / 3) - 1;
  assign w_sum    = r_acc + AW'(rdat_img) * AW'(tap_weight(4'(r_ph - 5'd1)));
  assign w_border = (w_xi < 3) || (w_xi >= X_MAX - 3) || (w_yi < 3) || (w_yi >= Y_MAX - 3);
  assign w_x_last = (w_xi == X_MAX - 1);
  assign w_y_last = (w_yi == Y_MAX - 1);

  assign w_c9     = {1'b0, rdat_conv_fast};
  assign w_p9     = {1'b0, r_p};
  assign w_t9     = CW'(r_t);
  assign w_b      = w_c9 > w_p9 + w_t9;
  assign w_d      = w_c9 + w_t9 < w_p9;
  assign w_corner = has_run9({w_b, r_bright}) | has_run9({w_d, r_dark});

  // FAST issues ring reads one phase after the centre; CIRCLE writes two phases after its read.
  assign w_ring_idx = (r_state == S_FAST) ? 4'(r_ph - 5'd1) : 4'(r_ph - 5'd2);
  assign w_cap_idx  = 4'(r_ph - 5'd2);

  always_comb begin
    new_trans = 1'b0;  img_done = 1'b0;
    x_addr_img = '0;   y_addr_img = '0;   ren_img = 1'b0;
    addr_params = '0;  ren_params = 1'b0;
    addr_write_params = '0; wen_params = 1'b0; wdat_params = '0;
    x_addr_conv = '0;  y_addr_conv = '0;  wen_conv = 1'b0;  wdat_conv = '0;
    x_addr_conv_fast = '0; y_addr_conv_fast = '0; ren_conv_fast = 1'b0;
    x_addr_fast = '0;  y_addr_fast = '0;  wen_fast = 1'b0;  wdat_fast = 1'b0; ren_fast = 1'b0;
    x_addr_circle = '0; y_addr_circle = '0; wen_circle = 1'b0; wdat_circle = '0;
    w_pix_done = 1'b0;
    case (r_state)
      S_PARAMS: begin
        new_trans   = (r_ph == 5'd0);
        ren_params  = (r_ph < 5'd3);
        addr_params = (r_ph == 5'd0) ? PW'(0) : (r_ph == 5'd1) ? PW'(1) : PW'(7);
      end
      S_CONV: begin
        if (r_ph == w_ntaps) begin
          wen_conv    = 1'b1;
          x_addr_conv = r_x;
          y_addr_conv = r_y;
          wdat_conv   = w_bypass ? rdat_img : w_sum[AW-1:4];
          w_pix_done  = 1'b1;
        end else begin
          ren_img    = 1'b1;
          x_addr_img = XW'(clampi(w_xi + w_tdx, X_MAX - 1));
          y_addr_img = YW'(clampi(w_yi + w_tdy, Y_MAX - 1));
        end
      end
      S_FAST: begin
        x_addr_fast = r_x;
        y_addr_fast = r_y;
        if (w_border) begin
          wen_fast   = 1'b1;
          w_pix_done = 1'b1;
        end else if (r_ph == 5'd17) begin
          wen_fast   = 1'b1;
          wdat_fast  = w_corner;
          w_pix_done = 1'b1;
        end else begin
          ren_conv_fast    = 1'b1;
          x_addr_conv_fast = (r_ph == 5'd0) ? r_x : XW'(w_xi + RING_DX[w_ring_idx]);
          y_addr_conv_fast = (r_ph == 5'd0) ? r_y : YW'(w_yi + RING_DY[w_ring_idx]);
        end
      end
      S_CIRCLE: begin
        if (r_ph == 5'd0) begin
          ren_fast    = 1'b1;
          x_addr_fast = r_x;
          y_addr_fast = r_y;
        end else if (r_ph == 5'd1) begin
          w_pix_done = !rdat_fast;
        end else begin
          wen_circle    = 1'b1;
          x_addr_circle = XW'(w_xi + RING_DX[w_ring_idx]);
          y_addr_circle = YW'(w_yi + RING_DY[w_ring_idx]);
          wdat_circle   = '1;
          w_pix_done    = (r_ph == 5'd17);
        end
      end
      S_FINISH: begin
        wen_params        = 1'b1;
        addr_write_params = PW'(7);
        wdat_params       = r_fc + PARAM_DEPTH'(1);
      end
      S_DONE:  img_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_WAIT;
      r_cnt    <= '0;
      r_ph     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_t      <= '0;
      r_k      <= '0;
      r_fc     <= '0;
      r_acc    <= '0;
      r_p      <= '0;
      r_bright <= '0;
      r_dark   <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (int'(r_cnt) == START_DELAY - 1) r_state <= S_PARAMS;
          else r_cnt <= r_cnt + DW'(1);
        end
        S_PARAMS: begin
          if (r_ph == 5'd1) r_t <= rdat_params;
          if (r_ph == 5'd2) r_k <= rdat_params;
          if (r_ph == 5'd3) begin
            r_fc    <= rdat_params;
            r_ph    <= '0;
            r_state <= S_CONV;
          end else begin
            r_ph <= r_ph + 5'd1;
          end
        end
        S_CONV, S_FAST, S_CIRCLE: begin
          if (r_state == S_CONV && r_ph != 5'd0 && r_ph != w_ntaps) r_acc <= w_sum;
          if (r_state == S_FAST && r_ph == 5'd1) r_p <= rdat_conv_fast;
          if (r_state == S_FAST && r_ph >= 5'd2 && r_ph <= 5'd16) begin
            r_bright[w_cap_idx] <= w_b;
            r_dark[w_cap_idx]   <= w_d;
          end
          if (w_pix_done) begin
            r_ph  <= '0;
            r_acc <= '0;
            if (w_x_last) begin
              r_x <= '0;
              if (w_y_last) begin
                r_y     <= '0;
                r_state <= r_state + 3'd1;  // CONV -> FAST -> CIRCLE -> FINISH
              end else begin
                r_y <= r_y + YW'(1);
              end
            end else begin
              r_x <= r_x + XW'(1);
            end
          end else begin
            r_ph <= r_ph + 5'd1;
          end
        end
        S_FINISH: r_state <= S_DONE;
        default:  r_state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_orb_fast_conv_core.sv
// Directed bench for orb_fast_conv_core on a 16x16 frame with behavioural SRAM models.
module tb_orb_fast_conv_core;

  localparam int XM = 16;
  localparam int YM = 16;
  localparam int SD = 32;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic tb_clr = 1'b0;
  always #5 clk = ~clk;

  logic       new_trans, img_done;
  logic [4:0] x_addr_img, y_addr_img, x_addr_conv, y_addr_conv;
  logic [4:0] x_addr_conv_fast, y_addr_conv_fast, x_addr_fast, y_addr_fast;
  logic [4:0] x_addr_circle, y_addr_circle;
  logic       ren_img, ren_params, wen_params, wen_conv, ren_conv_fast;
  logic       wen_fast, wdat_fast, ren_fast, rdat_fast, wen_circle;
  logic [2:0] addr_params, addr_write_params;
  logic [7:0] rdat_img, rdat_params, wdat_params, wdat_conv, rdat_conv_fast, wdat_circle;

  orb_fast_conv_core #(
    .NUM_PARAMS(8), .PARAM_DEPTH(8), .MAX_KERNEL(31), .X_MAX(XM), .Y_MAX(YM),
    .PIXEL_DEPTH(8), .START_DELAY(SD)
  ) u_dut (
    .clk(clk), .n_rst(n_rst), .new_trans(new_trans), .img_done(img_done),
    .x_addr_img(x_addr_img), .y_addr_img(y_addr_img), .ren_img(ren_img), .rdat_img(rdat_img),
    .addr_params(addr_params), .ren_params(ren_params), .rdat_params(rdat_params),
    .addr_write_params(addr_write_params), .wen_params(wen_params),
    .wdat_params(wdat_params),
    .x_addr_conv(x_addr_conv), .y_addr_conv(y_addr_conv), .wen_conv(wen_conv),
    .wdat_conv(wdat_conv),
    .x_addr_conv_fast(x_addr_conv_fast), .y_addr_conv_fast(y_addr_conv_fast),
    .ren_conv_fast(ren_conv_fast), .rdat_conv_fast(rdat_conv_fast),
    .x_addr_fast(x_addr_fast), .y_addr_fast(y_addr_fast), .wen_fast(wen_fast),
    .wdat_fast(wdat_fast), .ren_fast(ren_fast), .rdat_fast(rdat_fast),
    .x_addr_circle(x_addr_circle), .y_addr_circle(y_addr_circle), .wen_circle(wen_circle),
    .wdat_circle(wdat_circle)
  );

  wire any_out = |{new_trans, img_done, x_addr_img, y_addr_img, ren_img, addr_params,
                   ren_params, addr_write_params, wen_params, wdat_params, x_addr_conv,
                   y_addr_conv, wen_conv, wdat_conv, x_addr_conv_fast, y_addr_conv_fast,
                   ren_conv_fast, x_addr_fast, y_addr_fast, wen_fast, wdat_fast, ren_fast,
                   x_addr_circle, y_addr_circle, wen_circle, wdat_circle};
  wire any_strobe = |{ren_img, ren_params, wen_params, wen_conv, ren_conv_fast, wen_fast,
                      ren_fast, wen_circle};

  logic [7:0] img  [0:31][0:31];
  logic [7:0] conv [0:31][0:31];
  logic       fmap [0:31][0:31];
  logic [7:0] circ [0:31][0:31];
  logic [7:0] p_t, p_k, p7;
  int         circ_writes, parw_count;

  int rdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int rdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  // SRAM models; tb_clr reinitialises everything the DUT writes.
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int y = 0; y < 32; y++) begin
        for (int x = 0; x < 32; x++) begin
          conv[y][x] <= 8'hEE;
          fmap[y][x] <= 1'b1;
          circ[y][x] <= 8'd7;
        end
      end
      p7 <= 8'd0;
      circ_writes <= 0;
      parw_count <= 0;
    end else begin
      if (ren_img) rdat_img <= img[y_addr_img][x_addr_img];
      if (wen_conv) conv[y_addr_conv][x_addr_conv] <= wdat_conv;
      if (ren_conv_fast) rdat_conv_fast <= conv[y_addr_conv_fast][x_addr_conv_fast];
      if (wen_fast) fmap[y_addr_fast][x_addr_fast] <= wdat_fast;
      if (ren_fast) rdat_fast <= fmap[y_addr_fast][x_addr_fast];
      if (wen_circle) begin
        circ[y_addr_circle][x_addr_circle] <= wdat_circle;
        circ_writes <= circ_writes + 1;
      end
      if (ren_params)
        rdat_params <= (addr_params == 3'd0) ? p_t : (addr_params == 3'd1) ? p_k :
                       (addr_params == 3'd7) ? p7 : 8'd0;
      if (wen_params) begin
        parw_count <= parw_count + 1;
        if (addr_write_params == 3'd7) p7 <= wdat_params;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_img(input int v);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) img[y][x] = 8'(v);
  endtask

  task automatic set_ring(input int lo, input int n, input int v);
    for (int i = 0; i < n; i++) img[8 + rdy[(lo + i) % 16]][8 + rdx[(lo + i) % 16]] = 8'(v);
  endtask

  task automatic release_and_run();
    int n;
    n_rst = 1'b1;
    n = 0;
    while (!new_trans && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check_eq("new_trans_latency", n, SD);
    n = 0;
    while (!img_done && n < 20000) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check_eq("img_done", int'(img_done), 1);
  endtask

  task automatic reset_and_clear(input int t, input int k);
    p_t = 8'(t);
    p_k = 8'(k);
    n_rst = 1'b0;
    tb_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_clr = 1'b0;
    check_eq("reset_outputs", int'(any_out), 0);
  endtask

  task automatic run_frame(input int t, input int k);
    reset_and_clear(t, k);
    release_and_run();
  endtask

  function automatic int count_fast_ones();
    int c = 0;
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++) c += int'(fmap[y][x]);
    return c;
  endfunction

  function automatic int count_conv_not(input int v);
    int c = 0;
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++) c += (int'(conv[y][x]) != v) ? 1 : 0;
    return c;
  endfunction

  function automatic int count_circ_255();
    int c = 0;
    for (int y = 0; y < YM; y++)
      for (int x = 0; x < XM; x++) c += (circ[y][x] == 8'd255) ? 1 : 0;
    return c;
  endfunction

  initial begin
    int n;
    int ring_ok;

    // Flat frame, 3x3 kernel
    fill_img(100);
    run_frame(20, 3);
    check_eq("flat_conv_bad_pixels", count_conv_not(100), 0);
    check_eq("flat_fast_ones", count_fast_ones(), 0);
    check_eq("flat_circle_writes", circ_writes, 0);
    check_eq("flat_param7", int'(p7), 1);
    check_eq("flat_param_writes", parw_count, 1);
    repeat (4) @(negedge clk);
    check_eq("done_idle_strobes", int'(any_strobe), 0);
    check_eq("done_sticky", int'(img_done), 1);

    // Gaussian weights and edge replication
    fill_img(0);
    img[8][8] = 8'd200;
    img[0][0] = 8'd160;
    run_frame(20, 3);
    check_eq("conv_8_8", int'(conv[8][8]), 50);
    check_eq("conv_7_8", int'(conv[8][7]), 25);
    check_eq("conv_7_7", int'(conv[7][7]), 12);
    check_eq("conv_edge_0_0", int'(conv[0][0]), 90);
    check_eq("conv_edge_1_0", int'(conv[0][1]), 30);
    check_eq("conv_far_zero", int'(conv[4][12]), 0);

    // Bypass, single dark-ring corner and its circle overlay
    fill_img(0);
    img[8][8] = 8'd200;
    run_frame(20, 1);
    check_eq("bypass_conv_8_8", int'(conv[8][8]), 200);
    check_eq("corner_8_8", int'(fmap[8][8]), 1);
    check_eq("corner_count", count_fast_ones(), 1);
    check_eq("circle_writes", circ_writes, 16);
    ring_ok = 0;
    for (int i = 0; i < 16; i++) ring_ok += (circ[8 + rdy[i]][8 + rdx[i]] == 8'd255) ? 1 : 0;
    check_eq("circle_ring_255", ring_ok, 16);
    check_eq("circle_total_255", count_circ_255(), 16);
    check_eq("circle_centre_kept", int'(circ[8][8]), 7);

    // Large threshold suppresses the corner
    run_frame(250, 1);
    check_eq("t250_corner_count", count_fast_ones(), 0);
    check_eq("t250_circle_writes", circ_writes, 0);

    // 8 contiguous dark ring pixels: not a corner
    fill_img(100);
    set_ring(0, 8, 50);
    run_frame(20, 1);
    check_eq("dark8_no_corner", int'(fmap[8][8]), 0);

    // 9 dark ring pixels wrapping 12..4: corner
    fill_img(100);
    set_ring(12, 9, 50);
    run_frame(20, 1);
    check_eq("dark9_wrap_corner", int'(fmap[8][8]), 1);

    // Border pixel is never a corner
    fill_img(0);
    img[1][1] = 8'd200;
    run_frame(20, 1);
    check_eq("border_1_1", int'(fmap[1][1]), 0);
    check_eq("border_corner_count", count_fast_ones(), 0);

    // Reset asserted mid-CONV, then a clean rerun
    fill_img(100);
    reset_and_clear(20, 3);
    n_rst = 1'b1;
    n = 0;
    while (!wen_conv && n < 2000) begin
      @(posedge clk); @(negedge clk); n++;
    end
    check_eq("abort_conv_reached", int'(wen_conv), 1);
    repeat (37) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_eq("abort_outputs_zero", int'(any_out), 0);
    @(negedge clk);
    release_and_run();
    check_eq("abort_conv_bad_pixels", count_conv_not(100), 0);
    check_eq("abort_fast_ones", count_fast_ones(), 0);
    check_eq("abort_param7", int'(p7), 1);
    check_eq("abort_param_writes", parw_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
